mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 119 +++++++++++
 tb/tb_mem_port_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates a single-port RAM between CPU and FPGA requesters: one access per 3 cycles,
// round-robin on contention unless the FPGA holds its burst lock.
module mem_port_arbiter #(
  parameter int AW = 12,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_ack,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_stall,
  input  logic          fpga_req,
  input  logic          fpga_we,
  input  logic          fpga_lock,
  input  logic [AW-1:0] fpga_addr,
  input  logic [DW-1:0] fpga_wdata,
  output logic          fpga_ack,
  output logic [DW-1:0] fpga_rdata,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  output logic          ram_we,
  input  logic [DW-1:0] ram_rdata
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CPU_ACC  = 3'd1,
    FPGA_ACC = 3'd2,
    CPU_RSP  = 3'd3,
    FPGA_RSP = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic          last_fpga_q, last_fpga_d;
  logic [AW-1:0] acc_addr_q, acc_addr_d;
  logic [DW-1:0] acc_wdata_q, acc_wdata_d;
  logic          acc_we_q, acc_we_d;
  logic [DW-1:0] cpu_rdata_q, fpga_rdata_q;
  logic          grant_cpu, grant_fpga;

  // FPGA wins contention when locked or when the CPU was served last.
  assign grant_fpga = fpga_req && (!cpu_req || fpga_lock || !last_fpga_q);
  assign grant_cpu  = cpu_req && !grant_fpga;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_fpga_q  <= 1'b1;
      acc_addr_q   <= '0;
      acc_wdata_q  <= '0;
      acc_we_q     <= 1'b0;
      cpu_rdata_q  <= '0;
      fpga_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      last_fpga_q <= last_fpga_d;
      acc_addr_q  <= acc_addr_d;
      acc_wdata_q <= acc_wdata_d;
      acc_we_q    <= acc_we_d;
      if (state_q == CPU_RSP) cpu_rdata_q <= ram_rdata;
      if (state_q == FPGA_RSP) fpga_rdata_q <= ram_rdata;
    end
  end

  always_comb begin
    state_d     = state_q;
    last_fpga_d = last_fpga_q;
    acc_addr_d  = acc_addr_q;
    acc_wdata_d = acc_wdata_q;
    acc_we_d    = acc_we_q;
    ram_addr    = '0;
    ram_wdata   = '0;
    ram_we      = 1'b0;
    cpu_ack     = 1'b0;
    fpga_ack    = 1'b0;
    case (state_q)
      IDLE: begin
        // Latch the granted request so a requester dropping req cannot corrupt the access.
        if (grant_fpga) begin
          state_d     = FPGA_ACC;
          last_fpga_d = 1'b1;
          acc_addr_d  = fpga_addr;
          acc_wdata_d = fpga_wdata;
          acc_we_d    = fpga_we;
        end else if (grant_cpu) begin
          state_d     = CPU_ACC;
          last_fpga_d = 1'b0;
          acc_addr_d  = cpu_addr;
          acc_wdata_d = cpu_wdata;
          acc_we_d    = cpu_we;
        end
      end
      CPU_ACC, FPGA_ACC: begin
        ram_addr  = acc_addr_q;
        ram_wdata = acc_wdata_q;
        ram_we    = acc_we_q & ~rst;
        state_d   = (state_q == CPU_ACC) ? CPU_RSP : FPGA_RSP;
      end
      CPU_RSP: begin
        cpu_ack = ~rst;
        state_d = IDLE;
      end
      FPGA_RSP: begin
        fpga_ack = ~rst;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign cpu_rdata  = cpu_rdata_q;
  assign fpga_rdata = fpga_rdata_q;
  assign cpu_stall  = cpu_req & ~cpu_ack;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus a randomized run against a
// transaction-level model of the arbitration rules.
module tb_mem_port_arbiter;
  localparam int AW = 12;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          cpu_req, cpu_we, cpu_ack, cpu_stall;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata;
  logic          fpga_req, fpga_we, fpga_lock, fpga_ack;
  logic [AW-1:0] fpga_addr;
  logic [DW-1:0] fpga_wdata, fpga_rdata;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata, ram_rdata;
  logic          ram_we;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .fpga_req(fpga_req), .fpga_we(fpga_we), .fpga_lock(fpga_lock),
    .fpga_addr(fpga_addr), .fpga_wdata(fpga_wdata),
    .fpga_ack(fpga_ack), .fpga_rdata(fpga_rdata),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_rdata(ram_rdata)
  );

  // Initial RAM content: word 0x010 holds 0xDEADBEEF, others a scrambled pattern.
  function automatic logic [31:0] pat(input logic [11:0] a);
    return 32'hDEADBEEF ^ ({20'd0, a ^ 12'h010} * 32'h9E3779B1);
  endfunction

  // Synchronous read-first RAM; stored value is XORed with pat so zero-init means pat.
  bit [31:0] ram_mem [0:4095];
  always @(posedge clk) begin
    ram_rdata <= ram_mem[ram_addr] ^ pat(ram_addr);
    if (ram_we) ram_mem[ram_addr] <= ram_wdata ^ pat(ram_addr);
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    fpga_req = 0; fpga_we = 0; fpga_lock = 0; fpga_addr = '0; fpga_wdata = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    repeat (3) cyc();
    cpu_req = 1'b1;
    smp();
    n_tests++; if (cpu_ack !== 1'b0) begin n_fail++; $display("FAIL rst_cpu_ack: got %b want 0", cpu_ack); end
    n_tests++; if (fpga_ack !== 1'b0) begin n_fail++; $display("FAIL rst_fpga_ack: got %b want 0", fpga_ack); end
    n_tests++; if (ram_we !== 1'b0) begin n_fail++; $display("FAIL rst_ram_we: got %b want 0", ram_we); end
    n_tests++; if (ram_addr !== 12'h000) begin n_fail++; $display("FAIL rst_ram_addr: got %h want 000", ram_addr); end
    n_tests++; if (cpu_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_cpu_rdata: got %h want 0", cpu_rdata); end
    n_tests++; if (fpga_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_fpga_rdata: got %h want 0", fpga_rdata); end
    n_tests++; if (cpu_stall !== 1'b1) begin n_fail++; $display("FAIL rst_cpu_stall: got %b want 1", cpu_stall); end
    cyc();
    cpu_req = 1'b0;
    rst = 1'b0;
    cyc();
  endtask

  task automatic test_cpu_read();
    cpu_req = 1; cpu_we = 0; cpu_addr = 12'h010;
    smp();
    n_tests++; if (cpu_ack !== 1'b0 || ram_we !== 1'b0) begin n_fail++; $display("FAIL rd_n_idle: ack=%b we=%b want 0 0", cpu_ack, ram_we); end
    n_tests++; if (cpu_stall !== 1'b1) begin n_fail++; $display("FAIL rd_stall: got %b want 1", cpu_stall); end
    cyc(); smp();
    n_tests++; if (ram_addr !== 12'h010 || ram_we !== 1'b0) begin n_fail++; $display("FAIL rd_access: addr=%h we=%b want 010 0", ram_addr, ram_we); end
    n_tests++; if (cpu_ack !== 1'b0) begin n_fail++; $display("FAIL rd_early_ack: got %b want 0", cpu_ack); end
    cyc(); smp();
    n_tests++; if (cpu_ack !== 1'b1 || cpu_stall !== 1'b0) begin n_fail++; $display("FAIL rd_ack: ack=%b stall=%b want 1 0", cpu_ack, cpu_stall); end
    n_tests++; if (ram_addr !== 12'h000) begin n_fail++; $display("FAIL rd_rsp_addr: got %h want 000", ram_addr); end
    cyc();
    cpu_req = 0;
    smp();
    n_tests++; if (cpu_ack !== 1'b0) begin n_fail++; $display("FAIL rd_ack_len: got %b want 0", cpu_ack); end
    n_tests++; if (cpu_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rd_data: got %h want deadbeef", cpu_rdata); end
    cyc();
  endtask

  task automatic test_fpga_write();
    fpga_req = 1; fpga_we = 1; fpga_addr = 12'h004; fpga_wdata = 32'h12345678;
    smp();
    n_tests++; if (ram_we !== 1'b0 || fpga_ack !== 1'b0) begin n_fail++; $display("FAIL wr_n_idle: we=%b ack=%b want 0 0", ram_we, fpga_ack); end
    cyc(); smp();
    n_tests++; if (ram_we !== 1'b1 || ram_addr !== 12'h004 || ram_wdata !== 32'h12345678) begin
      n_fail++; $display("FAIL wr_access: we=%b addr=%h data=%h want 1 004 12345678", ram_we, ram_addr, ram_wdata); end
    cyc(); smp();
    n_tests++; if (fpga_ack !== 1'b1 || ram_we !== 1'b0) begin n_fail++; $display("FAIL wr_ack: ack=%b we=%b want 1 0", fpga_ack, ram_we); end
    n_tests++; if (cpu_ack !== 1'b0) begin n_fail++; $display("FAIL wr_cpu_ack: got %b want 0", cpu_ack); end
    cyc();
    fpga_req = 0; fpga_we = 0;
    cpu_req = 1; cpu_we = 0; cpu_addr = 12'h004;
    smp();
    n_tests++; if (ram_we !== 1'b0) begin n_fail++; $display("FAIL wr_we_len: got %b want 0", ram_we); end
    n_tests++; if (fpga_rdata !== pat(12'h004)) begin n_fail++; $display("FAIL wr_fpga_rdata: got %h want %h", fpga_rdata, pat(12'h004)); end
    cyc(); smp(); cyc(); smp();
    n_tests++; if (cpu_ack !== 1'b1) begin n_fail++; $display("FAIL wr_rb_ack: got %b want 1", cpu_ack); end
    cyc();
    cpu_req = 0;
    smp();
    n_tests++; if (cpu_rdata !== 32'h12345678) begin n_fail++; $display("FAIL wr_readback: got %h want 12345678", cpu_rdata); end
    cyc();
  endtask

  task automatic test_round_robin();
    bit exp_c, exp_f;
    rst = 1;
    cpu_req = 1; cpu_we = 0; cpu_addr = 12'h020;
    fpga_req = 1; fpga_we = 0; fpga_addr = 12'h030; fpga_lock = 0;
    cyc();
    rst = 0;
    for (int c = 0; c < 13; c++) begin
      smp();
      exp_c = (c == 2 || c == 8);
      exp_f = (c == 5 || c == 11);
      n_tests++; if (cpu_ack !== exp_c) begin n_fail++; $display("FAIL rr_cpu_ack c%0d: got %b want %b", c, cpu_ack, exp_c); end
      n_tests++; if (fpga_ack !== exp_f) begin n_fail++; $display("FAIL rr_fpga_ack c%0d: got %b want %b", c, fpga_ack, exp_f); end
      cyc();
    end
    idle_inputs();
    repeat (4) cyc();
  endtask

  task automatic test_lock();
    int facks, cacks, stall_bad, k;
    bit got_c, got_f;
    facks = 0; cacks = 0; stall_bad = 0;
    cpu_req = 1; cpu_we = 0; cpu_addr = 12'h040;
    fpga_req = 1; fpga_we = 0; fpga_addr = 12'h050; fpga_lock = 1;
    for (int i = 0; i < 40 && facks < 4; i++) begin
      smp();
      if (fpga_ack) facks++;
      if (cpu_ack) cacks++;
      if (!cpu_stall) stall_bad++;
      if (cpu_ack && fpga_ack) stall_bad++;
      cyc();
    end
    n_tests++; if (facks != 4) begin n_fail++; $display("FAIL lock_fpga_acks: got %0d want 4", facks); end
    n_tests++; if (cacks != 0) begin n_fail++; $display("FAIL lock_cpu_acks: got %0d want 0", cacks); end
    n_tests++; if (stall_bad != 0) begin n_fail++; $display("FAIL lock_stall: %0d bad cycles want 0", stall_bad); end
    fpga_lock = 0;
    got_c = 0; got_f = 0; k = 0;
    for (int i = 0; i < 10; i++) begin
      smp();
      if (cpu_ack || fpga_ack) begin got_c = cpu_ack; got_f = fpga_ack; k = i; break; end
      cyc();
    end
    n_tests++; if (got_c !== 1'b1 || got_f !== 1'b0) begin n_fail++; $display("FAIL lock_release_grant: cpu=%b fpga=%b want 1 0", got_c, got_f); end
    n_tests++; if (k != 2) begin n_fail++; $display("FAIL lock_release_lat: got %0d want 2", k); end
    cyc();
    idle_inputs();
    repeat (3) cyc();
  endtask

  task automatic test_reset_mid();
    cpu_req = 1; cpu_we = 1; cpu_addr = 12'h060; cpu_wdata = 32'hCAFEF00D;
    smp();
    cyc();
    rst = 1;
    smp();
    n_tests++; if (ram_we !== 1'b0 || cpu_ack !== 1'b0) begin n_fail++; $display("FAIL rm_acc: we=%b ack=%b want 0 0", ram_we, cpu_ack); end
    cyc();
    rst = 0;
    cpu_we = 0;
    smp();
    n_tests++; if (cpu_ack !== 1'b0 || ram_we !== 1'b0) begin n_fail++; $display("FAIL rm_after: ack=%b we=%b want 0 0", cpu_ack, ram_we); end
    n_tests++; if (cpu_rdata !== 32'h0) begin n_fail++; $display("FAIL rm_rdata_clr: got %h want 0", cpu_rdata); end
    cyc(); smp();
    n_tests++; if (ram_addr !== 12'h060 || ram_we !== 1'b0 || cpu_ack !== 1'b0) begin
      n_fail++; $display("FAIL rm_reissue: addr=%h we=%b ack=%b want 060 0 0", ram_addr, ram_we, cpu_ack); end
    cyc(); smp();
    n_tests++; if (cpu_ack !== 1'b1) begin n_fail++; $display("FAIL rm_reissue_ack: got %b want 1", cpu_ack); end
    cyc();
    cpu_req = 0;
    smp();
    n_tests++; if (cpu_rdata !== pat(12'h060)) begin n_fail++; $display("FAIL rm_no_write: got %h want %h", cpu_rdata, pat(12'h060)); end
    cyc();
  endtask

  task automatic test_drop();
    int extra;
    cpu_req = 1; cpu_we = 0; cpu_addr = 12'h010;
    smp();
    cyc();
    cpu_req = 0;
    smp();
    n_tests++; if (ram_addr !== 12'h010) begin n_fail++; $display("FAIL drop_access: got %h want 010", ram_addr); end
    cyc(); smp();
    n_tests++; if (cpu_ack !== 1'b1) begin n_fail++; $display("FAIL drop_ack: got %b want 1", cpu_ack); end
    extra = 0;
    for (int i = 0; i < 5; i++) begin
      cyc(); smp();
      if (cpu_ack || fpga_ack || ram_we || ram_addr != 0) extra++;
    end
    n_tests++; if (extra != 0) begin n_fail++; $display("FAIL drop_quiet: %0d active cycles want 0", extra); end
    n_tests++; if (cpu_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL drop_rdata: got %h want deadbeef", cpu_rdata); end
  endtask

  // Randomized traffic checked against a transaction-level model of the arbitration rules.
  logic [31:0] mm [int];

  task automatic test_random();
    int free_at, acc_c, ack_c, last_fpga;
    bit cpend, fpend, cack_prev, fack_prev, t_cpu, t_we, win_f, exp_ca, exp_fa, exp_acc;
    logic [11:0] t_addr;
    logic [31:0] t_wdata, exp_crd, exp_frd, old;
    cyc();
    rst = 1; idle_inputs();
    cyc();
    rst = 0;
    free_at = 0; acc_c = -1; ack_c = -1; last_fpga = 1;
    cpend = 0; fpend = 0; cack_prev = 0; fack_prev = 0;
    t_cpu = 0; t_we = 0; t_addr = '0; t_wdata = '0;
    exp_crd = '0; exp_frd = '0;
    for (int c = 0; c < 1500; c++) begin
      if (cack_prev) cpend = 0;
      if (fack_prev) fpend = 0;
      if (!cpend && $urandom_range(0, 2) == 0) begin
        cpend = 1; cpu_we = $urandom_range(0, 1) == 1;
        cpu_addr = 12'h100 + 12'($urandom_range(0, 15)); cpu_wdata = $urandom;
      end
      if (!fpend && $urandom_range(0, 2) == 0) begin
        fpend = 1; fpga_we = $urandom_range(0, 1) == 1;
        fpga_addr = 12'h100 + 12'($urandom_range(0, 15)); fpga_wdata = $urandom;
      end
      cpu_req = cpend; fpga_req = fpend;
      fpga_lock = $urandom_range(0, 3) == 0;
      if (c >= free_at && (cpu_req || fpga_req)) begin
        if (cpu_req && fpga_req) win_f = fpga_lock || (last_fpga == 0);
        else win_f = fpga_req;
        t_cpu = !win_f; last_fpga = win_f ? 1 : 0;
        t_we = win_f ? fpga_we : cpu_we;
        t_addr = win_f ? fpga_addr : cpu_addr;
        t_wdata = win_f ? fpga_wdata : cpu_wdata;
        acc_c = c + 1; ack_c = c + 2; free_at = c + 3;
      end
      smp();
      exp_acc = (c == acc_c);
      exp_ca = (c == ack_c) && t_cpu;
      exp_fa = (c == ack_c) && !t_cpu;
      n_tests++; if (ram_we !== (exp_acc && t_we)) begin n_fail++; $display("FAIL rnd_we c%0d: got %b want %b", c, ram_we, exp_acc && t_we); end
      n_tests++; if (ram_addr !== (exp_acc ? t_addr : 12'h0)) begin n_fail++; $display("FAIL rnd_addr c%0d: got %h want %h", c, ram_addr, exp_acc ? t_addr : 12'h0); end
      n_tests++; if (ram_wdata !== (exp_acc ? t_wdata : 32'h0)) begin n_fail++; $display("FAIL rnd_wdata c%0d: got %h want %h", c, ram_wdata, exp_acc ? t_wdata : 32'h0); end
      n_tests++; if (cpu_ack !== exp_ca) begin n_fail++; $display("FAIL rnd_cpu_ack c%0d: got %b want %b", c, cpu_ack, exp_ca); end
      n_tests++; if (fpga_ack !== exp_fa) begin n_fail++; $display("FAIL rnd_fpga_ack c%0d: got %b want %b", c, fpga_ack, exp_fa); end
      n_tests++; if (cpu_stall !== (cpu_req && !exp_ca)) begin n_fail++; $display("FAIL rnd_stall c%0d: got %b want %b", c, cpu_stall, cpu_req && !exp_ca); end
      n_tests++; if (cpu_rdata !== exp_crd) begin n_fail++; $display("FAIL rnd_cpu_rdata c%0d: got %h want %h", c, cpu_rdata, exp_crd); end
      n_tests++; if (fpga_rdata !== exp_frd) begin n_fail++; $display("FAIL rnd_fpga_rdata c%0d: got %h want %h", c, fpga_rdata, exp_frd); end
      if (c == ack_c) begin
        old = mm.exists(int'(t_addr)) ? mm[int'(t_addr)] : pat(t_addr);
        if (t_we) mm[int'(t_addr)] = t_wdata;
        if (t_cpu) exp_crd = old; else exp_frd = old;
      end
      cack_prev = cpu_ack; fack_prev = fpga_ack;
      cyc();
    end
    idle_inputs();
    repeat (3) cyc();
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_cpu_read();
    test_fpga_write();
    test_round_robin();
    test_lock();
    test_reset_mid();
    test_drop();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
